// File: rtl/conv_window_gen.sv
// conv_window_gen: converts a raster-order pixel stream into 5x5 windows
// for the convolution PE. Four line buffers hold the previous four rows;
// a 5x5 shift-register window receives one new column per accepted pixel.
// Windows whose top-left corner fits entirely inside one frame are emitted
// through a 1-deep valid/ready output stage.
module conv_window_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [25*DATA_W-1:0]  win_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [7:0]            win_row,
    output logic [7:0]            win_col,
    output logic                  win_last
);

    localparam int         COL_AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] COL_MAX = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_MAX = 8'(IMG_H - 1);

    // Position of the pixel that will be accepted next
    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;

    // Line buffers, lb0 holds the oldest row
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb3 [IMG_W];

    // Window register, element k = row*5 + col
    logic [DATA_W-1:0] win_q [25];
    logic [DATA_W-1:0] win_d [25];

    // Output stage
    logic       valid_q, valid_d;
    logic       last_q,  last_d;
    logic [7:0] wrow_q,  wrow_d;
    logic [7:0] wcol_q,  wcol_d;

    logic              accept;
    logic              emit;
    logic [COL_AW-1:0] lb_idx;
    logic [DATA_W-1:0] new_col [5];

    // A held window blocks intake; a consumed one frees the stage in the
    // same cycle, so continuous ready never inserts a bubble.
    assign pix_ready = !rst && !clear && (!valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign emit      = accept && (row_q >= 8'd4) && (col_q >= 8'd4);
    assign lb_idx    = col_q[COL_AW-1:0];

    // New right-hand column of the window, top (oldest row) to bottom
    assign new_col[0] = lb0[lb_idx];
    assign new_col[1] = lb1[lb_idx];
    assign new_col[2] = lb2[lb_idx];
    assign new_col[3] = lb3[lb_idx];
    assign new_col[4] = pix_data;

    // Line buffer column shift on every accepted pixel
    // NOTE: the line buffers are plain storage with no reset; stale contents
    // only feed windows that are never emitted, and leaving reset off lets
    // them map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            // NOTE: non-blocking assignments make every stage read the old
            // value, so the four writes form a proper shift chain.
            lb0[lb_idx] <= lb1[lb_idx];
            lb1[lb_idx] <= lb2[lb_idx];
            lb2[lb_idx] <= lb3[lb_idx];
            lb3[lb_idx] <= pix_data;
        end
    end

    // Next-state logic for counters, window register and output stage
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves one unassigned, which would infer a latch.
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = valid_q;
        last_d  = last_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;

        if (accept) begin
            if (col_q == COL_MAX) begin
                col_d = 8'd0;
                row_d = (row_q == ROW_MAX) ? 8'd0 : row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win_d[i*5+j] = win_q[i*5+j+1];
                end
                win_d[i*5+4] = new_col[i];
            end
        end

        if (emit) begin
            valid_d = 1'b1;
            wrow_d  = row_q - 8'd4;
            wcol_d  = col_q - 8'd4;
            last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
        end else if (win_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        // Frame restart drops any pending window and rewinds the counters
        if (clear) begin
            col_d   = 8'd0;
            row_d   = 8'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            wrow_d  = 8'd0;
            wcol_d  = 8'd0;
            for (int k = 0; k < 25; k++) begin
                win_d[k] = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            wrow_q  <= 8'd0;
            wcol_q  <= 8'd0;
            for (int k = 0; k < 25; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            win_q   <= win_d;
        end
    end

    // Flatten the window onto the PE input bus, element k on slice k
    for (genvar k = 0; k < 25; k++) begin : g_flat
        assign win_data[DATA_W*k +: DATA_W] = win_q[k];
    end

    assign win_valid = valid_q;
    assign win_last  = last_q;
    assign win_row   = wrow_q;
    assign win_col   = wcol_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 32x32 instance and an 8x6 instance share the
// stimulus; sel_q picks which one is driven and observed. A small pixel model
// produces the expected window contents and coordinates.
module tb_conv_window_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic [7:0]   pix_data = 8'd0;
    logic         pix_valid_drv = 1'b0;
    logic         win_ready = 1'b0;
    logic         sel_q = 1'b0;

    logic         pv_big, pv_sml;
    logic         rdy_big, rdy_sml, val_big, val_sml, last_big, last_sml;
    logic [199:0] dat_big, dat_sml;
    logic [7:0]   row_big, row_sml, col_big, col_sml;

    logic         s_valid, s_ready, s_last;
    logic [199:0] s_data;
    logic [7:0]   s_row, s_col;

    int n_cmp = 0;
    int n_mis = 0;

    logic [199:0] first_win, last_win;
    logic [7:0]   last_row, last_col;
    logic         last_flag;

    always #5 clk = ~clk;

    assign pv_big = pix_valid_drv && !sel_q;
    assign pv_sml = pix_valid_drv && sel_q;

    assign s_valid = sel_q ? val_sml  : val_big;
    assign s_ready = sel_q ? rdy_sml  : rdy_big;
    assign s_last  = sel_q ? last_sml : last_big;
    assign s_data  = sel_q ? dat_sml  : dat_big;
    assign s_row   = sel_q ? row_sml  : row_big;
    assign s_col   = sel_q ? col_sml  : col_big;

    conv_window_gen #(.IMG_W(32), .IMG_H(32), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .pix_data(pix_data), .pix_valid(pv_big), .pix_ready(rdy_big),
        .win_data(dat_big), .win_valid(val_big), .win_ready(win_ready),
        .win_row(row_big), .win_col(col_big), .win_last(last_big)
    );

    conv_window_gen #(.IMG_W(8), .IMG_H(6), .DATA_W(8)) dut_s (
        .clk(clk), .rst(rst), .clear(clear),
        .pix_data(pix_data), .pix_valid(pv_sml), .pix_ready(rdy_sml),
        .win_data(dat_sml), .win_valid(val_sml), .win_ready(win_ready),
        .win_row(row_sml), .win_col(col_sml), .win_last(last_sml)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int f, input int r, input int c, input int w);
        return 8'((r * w + c + f * 13) & 255);
    endfunction

    function automatic logic [199:0] exp_win(input int f, input int wr, input int wc, input int w);
        logic [199:0] e;
        e = '0;
        for (int k = 0; k < 25; k++) begin
            e[8*k +: 8] = pix(f, wr + k / 5, wc + k % 5, w);
        end
        return e;
    endfunction

    // Drive nfr frames of w x h pixels into the selected instance and check
    // every consumed window. bp > 0 stalls the output for bp cycles when the
    // first window shows up. abort_at > 0 stops after that many accepts.
    task automatic stream(input bit sel, input int w, input int h, input int nfr,
                          input int pv_pct, input int wr_pct, input int bp, input int abort_at);
        int nw = (w - 4) * (h - 4);
        int fpx = w * h;
        int total = fpx * nfr;
        int acc = 0, got = 0, cyc = 0, stall = 0, n_last = 0;
        int f, m, er, ec;
        bit first = 1'b1;
        bit hold = 1'b0;
        logic [199:0] snap;
        logic [7:0] snap_r, snap_c;
        logic snap_l;
        sel_q = sel;
        while (cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                check("hold_data", s_data, snap);
                check("hold_row", s_row, snap_r);
                check("hold_col", s_col, snap_c);
                check("hold_last", s_last, snap_l);
            end
            if (s_valid && first) begin
                check("first_latency", acc, 4 * w + 5);
                first = 1'b0;
                stall = bp;
            end
            win_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < wr_pct);
            if (stall > 0) stall--;
            if (acc < total && (abort_at == 0 || acc < abort_at)) begin
                pix_valid_drv = ($urandom_range(99) < pv_pct);
                pix_data = pix(acc / fpx, (acc % fpx) / w, acc % w, w);
            end else begin
                pix_valid_drv = 1'b0;
            end
            #1;
            if (s_valid && !win_ready) begin
                check("hold_ready", s_ready, 1'b0);
                hold = 1'b1;
                snap = s_data;
                snap_r = s_row;
                snap_c = s_col;
                snap_l = s_last;
            end else begin
                hold = 1'b0;
            end
            if (s_valid && win_ready) begin
                f = got / nw;
                m = got % nw;
                er = m / (w - 4);
                ec = m % (w - 4);
                check("win_row", s_row, er);
                check("win_col", s_col, ec);
                check("win_last", s_last, (m == nw - 1));
                check("win_data", s_data, exp_win(f, er, ec, w));
                if (got == 0) first_win = s_data;
                if (s_last) n_last++;
                last_win = s_data;
                last_row = s_row;
                last_col = s_col;
                last_flag = s_last;
                got++;
            end
            if (pix_valid_drv && s_ready) acc++;
            if (abort_at != 0 && acc == abort_at) begin
                @(posedge clk);
                #1;
                pix_valid_drv = 1'b0;
                return;
            end
            if (acc == total && got == nfr * nw) break;
        end
        check("frame_pixels", acc, total);
        check("frame_windows", got, nfr * nw);
        check("frame_last_count", n_last, nfr);
        win_ready = 1'b1;
        pix_valid_drv = 1'b0;
        repeat (3) @(negedge clk);
        check("drain_idle", s_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready_low", rdy_big, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_ready_high", rdy_big, 1'b1);
        check("rst_valid", val_big, 1'b0);
        check("rst_last", last_big, 1'b0);
        check("rst_row", row_big, 8'd0);
        check("rst_col", col_big, 8'd0);
        check("rst_data", dat_big, 200'd0);

        // Full 32x32 frame, output always ready
        stream(1'b0, 32, 32, 1, 100, 100, 0, 0);
        check("first_e00", first_win[8*0 +: 8], 8'd0);
        check("first_e11", first_win[8*6 +: 8], 8'd33);
        check("first_e44", first_win[8*24 +: 8], 8'd132);
        check("last_row", last_row, 8'd27);
        check("last_col", last_col, 8'd27);
        check("last_flag", last_flag, 1'b1);
        check("last_e44", last_win[8*24 +: 8], 8'd255);

        // Backpressure for 10 cycles on the first window
        stream(1'b0, 32, 32, 1, 100, 100, 10, 0);

        // Random handshakes over three back-to-back frames
        stream(1'b0, 32, 32, 3, 50, 50, 0, 0);

        // Small 8x6 instance
        stream(1'b1, 8, 6, 1, 100, 100, 0, 0);
        check("small_first_e44", first_win[8*24 +: 8], 8'd36);
        check("small_last_row", last_row, 8'd1);
        check("small_last_col", last_col, 8'd3);
        check("small_last_flag", last_flag, 1'b1);

        // Reset at pixel 200, then a fresh frame
        stream(1'b0, 32, 32, 1, 100, 100, 0, 200);
        check("pre_rst_valid", val_big, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", val_big, 1'b0);
        check("mid_rst_data", dat_big, 200'd0);
        check("mid_rst_col", col_big, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", rdy_big, 1'b1);
        stream(1'b0, 32, 32, 1, 100, 100, 0, 0);

        // clear while a window is held with a pixel offered
        stream(1'b0, 32, 32, 1, 100, 100, 0, 133);
        check("pre_clr_valid", val_big, 1'b1);
        @(negedge clk);
        win_ready = 1'b0;
        clear = 1'b1;
        pix_valid_drv = 1'b1;
        pix_data = 8'hAA;
        #1;
        check("clr_ready", rdy_big, 1'b0);
        check("clr_valid_before", val_big, 1'b1);
        @(negedge clk);
        clear = 1'b0;
        pix_valid_drv = 1'b0;
        win_ready = 1'b1;
        #1;
        check("clr_valid_after", val_big, 1'b0);
        check("clr_row", row_big, 8'd0);
        check("clr_data", dat_big, 200'd0);
        stream(1'b0, 32, 32, 1, 100, 100, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the 5x5 convolution PE: turns a raster-order stream of unsigned 8-bit feature-map pixels into complete 5x5 windows.
- Each window is presented as 25 pixels, row-major, on one flattened bus that maps directly onto the PE feature-map inputs in_IF1..in_IF25.
- Sits between the feature-map SRAM reader and the PE array. Uses four line buffers plus a 5x5 shift-register window, with valid/ready handshakes on both sides.

Parameters:
- IMG_W, 32, feature-map width in pixels (range 5..256)
- IMG_H, 32, feature-map height in pixels (range 5..256)
- DATA_W, 8, pixel width in bits (unsigned)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous frame restart
- pix_data  input  DATA_W  incoming pixel, raster order (row 0 col 0 first)
- pix_valid  input  1  pix_data valid
- pix_ready  output  1  block can accept a pixel this cycle
- win_data  output  25*DATA_W  window; element k=i*5+j (row i, col j, row 0 = oldest/top) on bits [DATA_W*k+DATA_W-1 : DATA_W*k]; element k drives PE in_IF(k+1)
- win_valid  output  1  win_data holds a complete window
- win_ready  input  1  downstream (PE stage) consumes the window
- win_row  output  8  top-left row of the current window (0..IMG_H-5)
- win_col  output  8  top-left col of the current window (0..IMG_W-5)
- win_last  output  1  asserted with the final window of the frame

Behaviour:
- Accept rule: a pixel is accepted when pix_valid && pix_ready.
- Ready rule: pix_ready = !clear && (!win_valid || win_ready). This gives a 1-deep output stage with no bubble under continuous ready.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) address the accepted pixel. col increments on each accept. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame begins with no gap.
- Line buffers: four arrays lb0..lb3 of IMG_W x DATA_W, where lb0 holds the oldest row. On accept at column col, the window's new right-hand column (top to bottom) is {lb0[col], lb1[col], lb2[col], lb3[col], pix_data}. In the same cycle, lb0[col]<=lb1[col], lb1[col]<=lb2[col], lb2[col]<=lb3[col], lb3[col]<=pix_data.
- Window register: on accept, every window row shifts left by one column (column 0 dropped) and the new column enters at column 4. The window is updated on every accept, including during row/col warm-up.
- Window emission: on an accept with row>=4 && col>=4, win_valid is set next cycle (latency 1 clk).
  - win_row = row-4, win_col = col-4, registered alongside the window.
  - win_last = 1 iff row==IMG_H-1 && col==IMG_W-1.
- Clearing win_valid: cleared when win_ready is high and no new emitting accept occurs in the same cycle. A simultaneous consume and emitting accept keeps win_valid=1 with the new contents.
- Output stability: while win_valid && !win_ready, win_data, win_row, win_col and win_last hold stable and no pixel is accepted.
- Windows per frame: (IMG_W-4)*(IMG_H-4); 784 for 32x32. Windows that straddle row boundaries (col<4) are never emitted.
- Reset: col=0, row=0, win_valid=0, win_last=0, win_row=0, win_col=0, win_data=0, and pix_ready goes high once rst deasserts. Line buffer contents are not reset; stale data is never emitted because 4 fresh rows precede any window.
- clear: same effect as reset on counters, window register and outputs, applied at the clock edge. It overrides a coincident pix_valid, and that pixel is not accepted. A pending window is dropped.
- Reset or clear mid-frame: the next accepted pixel is treated as row 0 col 0.

Test Plan:
- 32x32 frame, pixel=(r*32+c)&255, win_ready=1:
  - First win_valid appears 1 clk after accept #132 (r4,c4), with element (i,j)=i*32+j, win_row=0, win_col=0.
  - Exactly 784 windows are emitted.
  - The last window has win_row=27, win_col=27, win_last=1, element(4,4)=(31*32+31)&255=255.
- Backpressure: win_ready=0 for 10 clks after the first window. pix_ready stays 0, win_data/win_row/win_col stay frozen, and the next window resumes with win_col=1.
- Random pix_valid and win_ready (50%) over 3 back-to-back 32x32 frames. A scoreboard checks 3x784 windows, correct coordinates, win_last once per frame, and no dropped or duplicated windows across the frame wrap.
- IMG_W=8, IMG_H=6: 8 windows (coords (0..1, 0..3)). The first appears after accept #36; win_last accompanies coordinate (1,3).
- rst asserted at pixel 200 of a frame, then a fresh frame: win_valid drops immediately, and the first new window follows accept #132 of the new frame with correct contents.
- clear pulsed with pix_valid=1 while win_valid=1 and win_ready=0: that pixel is not accepted, win_valid=0 next clk, and the following frame behaves as after reset.
